// File: rtl/mdu_if.sv
// Handshake and result bundle between the MIPS datapath and the multiply/divide unit.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mdu.sv
// Multi-cycle MULT/MULTU/DIV/DIVU plus MTHI/MTLO into HI/LO; only WIDTH=32 is supported.
// Define MDU_FAST_MUL_EN to compute MULT/MULTU with a single-cycle multiplier.
//
// state  | meaning
// S_IDLE | waiting for start; MTHI/MTLO applied here
// S_CALC | 32 shift-add / restoring shift-subtract iterations
// S_FIX  | sign correction, HI/LO write, done pulse next cycle
module mdu #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  mdu_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  localparam logic [4:0] LAST_ITER = 5'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] a_raw;
  logic             is_div_r, neg_lo_r, neg_hi_r, div_zero_r;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             done_r;

  logic             idle, launch, do_mthi, do_mtlo;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ok;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign idle    = (state == S_IDLE);
  assign launch  = idle && bus.start && !bus.op[2];
  assign do_mthi = idle && bus.start && (bus.op == 3'b100);
  assign do_mtlo = idle && bus.start && (bus.op == 3'b101);

  // op[0]=0 selects the signed variant of both MULT and DIV
  assign a_neg = !bus.op[0] && bus.a[WIDTH-1];
  assign b_neg = !bus.op[0] && bus.b[WIDTH-1];
  assign mag_a = a_neg ? -bus.a : bus.a;
  assign mag_b = b_neg ? -bus.b : bus.b;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_ok    = !div_diff[WIDTH];

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_lo_r ? -prod : prod;
  assign quo_fix  = neg_lo_r ? -acc_lo : acc_lo;
  assign rem_fix  = neg_hi_r ? -acc_hi : acc_hi;

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (launch) begin
`ifdef MDU_FAST_MUL_EN
          state_nxt = bus.op[1] ? S_CALC : S_FIX;
`else
          state_nxt = S_CALC;
`endif
        end
      end
      S_CALC:  if (cnt == LAST_ITER) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      opnd       <= '0;
      a_raw      <= '0;
      is_div_r   <= 1'b0;
      neg_lo_r   <= 1'b0;
      neg_hi_r   <= 1'b0;
      div_zero_r <= 1'b0;
    end else if (launch) begin
      cnt        <= '0;
      acc_hi     <= '0;
      a_raw      <= bus.a;
      is_div_r   <= bus.op[1];
      neg_lo_r   <= a_neg ^ b_neg;
      div_zero_r <= (bus.b == '0);
      if (bus.op[1]) begin
        acc_lo   <= mag_a;
        opnd     <= mag_b;
        neg_hi_r <= a_neg;
      end else begin
        acc_lo   <= mag_b;
        opnd     <= mag_a;
        neg_hi_r <= 1'b0;
`ifdef MDU_FAST_MUL_EN
        {acc_hi, acc_lo} <= fast_prod;
`endif
      end
    end else if (state == S_CALC) begin
      cnt <= cnt + 5'd1;
      if (is_div_r) begin
        acc_hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
      end else begin
        acc_hi <= mul_sum[WIDTH:1];
        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
      end
    end
  end

  // Divide by zero bypasses sign correction: the raw dividend goes to HI
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= (state == S_FIX);
      if (state == S_FIX) begin
        if (!is_div_r) begin
          {hi_r, lo_r} <= prod_fix;
        end else if (div_zero_r) begin
          hi_r <= a_raw;
          lo_r <= '1;
        end else begin
          hi_r <= rem_fix;
          lo_r <= quo_fix;
        end
      end else if (do_mthi) begin
        hi_r <= bus.a;
      end else if (do_mtlo) begin
        lo_r <= bus.a;
      end
    end
  end

  assign bus.busy = !idle;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule
